sram_1rw1r_param: RTL and testbench
===================================

// Module: sram_1rw1r_param
// PURPOSE
//  Parametrised, single-clock 1RW+1R synchronous SRAM model with registered inputs and a
//  post-reset memory-clear sequencer. Successor to the fixed 32x256 macro model: generic
//  width, depth and mask-lane size, read-valid strobes and same-address collision detection.
//  Sits between user-project logic and on-chip storage; drop-in for RAM macros in simulation/FPGA.
// PARAMETERS
//  DATA_WIDTH     32  word width in bits; must be a multiple of LANE_WIDTH
//  ADDR_WIDTH     8   address bits; depth RAM_DEPTH = 1<<ADDR_WIDTH
//  LANE_WIDTH     8   bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/LANE_WIDTH (derived)
//  CLEAR_ON_RESET 1   1: fill every word with CLEAR_VALUE after reset; 0: no clear, ready at once
//  CLEAR_VALUE    0   DATA_WIDTH-bit word written during clear
// PORTS
//  clk0         in   1            single clock; all logic on posedge
//  rst0         in   1            synchronous, active-high reset
//  csb0         in   1            port0 chip select, active low
//  web0         in   1            port0 write enable, active low (1 = read)
//  wmask0       in   NUM_WMASKS   port0 lane write mask, bit i -> din0[i*LANE_WIDTH +: LANE_WIDTH]
//  addr0        in   ADDR_WIDTH   port0 address
//  din0         in   DATA_WIDTH   port0 write data
//  dout0        out  DATA_WIDTH   port0 read data
//  dout0_valid  out  1            1-cycle strobe: dout0 updated this cycle
//  csb1         in   1            port1 (read-only) chip select, active low
//  addr1        in   ADDR_WIDTH   port1 address
//  dout1        out  DATA_WIDTH   port1 read data
//  dout1_valid  out  1            1-cycle strobe: dout1 updated this cycle
//  busy         out  1            high while clear sequence runs; requests ignored
//  collision    out  1            1-cycle strobe with dout1_valid: port1 read hit a port0 write
// BEHAVIOUR
//  - Reset (rst0=1 at posedge): dout0=dout1=0, dout0_valid=dout1_valid=0, collision=0,
//    clear counter=0, state=CLEAR if CLEAR_ON_RESET else READY; busy=CLEAR_ON_RESET.
//    Memory contents untouched by reset itself. Reset wins over every other input.
//  - FSM: CLEAR -> writes CLEAR_VALUE to mem[cnt], cnt++ each cycle; after word RAM_DEPTH-1
//    -> READY. Exactly RAM_DEPTH cycles with busy=1 after reset deasserts. READY is terminal
//    until next reset. Reset during CLEAR restarts at cnt=0.
//  - While busy: csb0/csb1 requests are dropped (no write, no valid, no collision).
//  - Read latency 1: request sampled at posedge N -> dout/valid visible after posedge N+1;
//    valid high for exactly that cycle. dout holds last read value otherwise.
//  - Port0 write (csb0=0, web0=0): each lane with wmask0[i]=1 written at the sampling edge;
//    other lanes keep old data. dout0/dout0_valid unchanged by writes. wmask0=0 is a no-op.
//  - Full throughput: one access per port per cycle, back-to-back, no bubbles.
//  - Port0 read + port1 read, same address: both return stored word.
//  - Port0 read of address written previous cycle returns new data (write visible next cycle).
//  - Collision: port0 write with wmask0!=0 and port1 read, addr0==addr1, same cycle ->
//    collision=1 alongside dout1_valid; dout1 content per CONFIGURATION.
// CONFIGURATION
//  SRAM_BYPASS_EN defined: on collision dout1 = merged word (masked lanes from din0, others
//    old data), i.e. write-first forwarding; collision still flagged.
//  SRAM_BYPASS_EN undefined: on collision dout1 = pre-write (old) word, read-first.
// TESTING
//  1 reset 1 cycle, default params -> busy=1 for exactly 256 cycles; then read all addrs -> 0.
//  2 busy=1, port0 write addr 0x10 din 0xDEADBEEF -> dropped; after busy, read 0x10 -> 0x0.
//  3 write 0x11223344 mask 0xF @0x05, then write 0xAABBCCDD mask 0x5 -> read 0x11BB33DD, 1-cycle latency.
//  4 word 0x0 @0x20; same cycle write 0xFFFFFFFF mask 0x3 + port1 read 0x20 -> collision=1;
//    dout1=0x0000FFFF with SRAM_BYPASS_EN, 0x00000000 without; next read -> 0x0000FFFF.
//  5 rst0 pulsed at clear cnt=100 -> busy stays high 256 more cycles; words 0..99 pre-written stay 0.
//  6 back-to-back reads 0..255 on both ports -> dout_valid high every cycle, data per address.

Source files
------------

// File: rtl/sram_1rw1r_param_if.sv
// Port bundle for sram_1rw1r_param: the 1RW port, the read-only port and the status strobes.
interface sram_1rw1r_param_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LANE_WIDTH = 8
);
    localparam int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH;

    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  busy;
    logic                  collision;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, dout0_valid, dout1, dout1_valid, busy, collision
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, dout0_valid, dout1, dout1_valid, busy, collision
    );
endinterface

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R synchronous SRAM with post-reset clear sequencer and collision flag.
// Optional feature macro: SRAM_BYPASS_EN (write-first forwarding to port1 on collision).
module sram_1rw1r_param #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    LANE_WIDTH     = 8,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input logic clk0,
    input logic rst0,
    sram_1rw1r_param_if.slave bus
);
    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int NUM_WMASKS = DATA_WIDTH / LANE_WIDTH;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [ADDR_WIDTH-1:0] r_clrCnt;
    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic                  w_busy;
    logic                  w_rd0;
    logic                  w_wr0;
    logic                  w_rd1;
    logic                  w_collision;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rd1Word;

    logic                  r_rd0Pend;
    logic                  r_rd1Pend;
    logic                  r_collPend;
    logic [DATA_WIDTH-1:0] r_rd0Data;
    logic [DATA_WIDTH-1:0] r_rd1Data;
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic                  r_dout0Valid;
    logic                  r_dout1Valid;
    logic                  r_collision;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (r_state == ST_CLEAR && r_clrCnt == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
            w_stateNext = ST_READY;
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_clrCnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clrCnt <= r_clrCnt + ADDR_WIDTH'(1);
        end
    end

    // Requests are only accepted once the clear sequence has finished.
    assign w_busy      = (r_state == ST_CLEAR);
    assign w_rd0       = !w_busy && !bus.csb0 && bus.web0;
    assign w_wr0       = !w_busy && !bus.csb0 && !bus.web0 && (|bus.wmask0);
    assign w_rd1       = !w_busy && !bus.csb1;
    assign w_collision = w_wr0 && w_rd1 && (bus.addr0 == bus.addr1);

    always_comb begin
        w_merged = r_mem[bus.addr0];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (bus.wmask0[i]) begin
                w_merged[i*LANE_WIDTH +: LANE_WIDTH] = bus.din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

`ifdef SRAM_BYPASS_EN
    assign w_rd1Word = w_collision ? w_merged : r_mem[bus.addr1];
`else
    assign w_rd1Word = r_mem[bus.addr1];
`endif

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (w_busy) begin
                r_mem[r_clrCnt] <= CLEAR_VALUE;
            end else if (w_wr0) begin
                r_mem[bus.addr0] <= w_merged;
            end
        end
    end

    // Array is read at the sampling edge (pre-write data) and presented one edge later.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_rd0Pend    <= 1'b0;
            r_rd1Pend    <= 1'b0;
            r_collPend   <= 1'b0;
            r_rd0Data    <= '0;
            r_rd1Data    <= '0;
            r_dout0      <= '0;
            r_dout1      <= '0;
            r_dout0Valid <= 1'b0;
            r_dout1Valid <= 1'b0;
            r_collision  <= 1'b0;
        end else begin
            r_rd0Pend  <= w_rd0;
            r_rd1Pend  <= w_rd1;
            r_collPend <= w_collision;
            if (w_rd0) begin
                r_rd0Data <= r_mem[bus.addr0];
            end
            if (w_rd1) begin
                r_rd1Data <= w_rd1Word;
            end
            r_dout0Valid <= r_rd0Pend;
            r_dout1Valid <= r_rd1Pend;
            r_collision  <= r_collPend;
            if (r_rd0Pend) begin
                r_dout0 <= r_rd0Data;
            end
            if (r_rd1Pend) begin
                r_dout1 <= r_rd1Data;
            end
        end
    end

    assign bus.dout0       = r_dout0;
    assign bus.dout0_valid = r_dout0Valid;
    assign bus.dout1       = r_dout1;
    assign bus.dout1_valid = r_dout1Valid;
    assign bus.busy        = w_busy;
    assign bus.collision   = r_collision;
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed self-checking bench for sram_1rw1r_param with default parameters.
module tb_sram_1rw1r_param;
    logic clk0 = 1'b0;
    logic rst0 = 1'b1;
    int   total = 0;
    int   bad = 0;

    sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .LANE_WIDTH(8)) bus();

    sram_1rw1r_param dut (
        .clk0 (clk0),
        .rst0 (rst0),
        .bus  (bus)
    );

    always #5 clk0 = ~clk0;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        bus.csb0   = 1'b1;
        bus.web0   = 1'b1;
        bus.wmask0 = 4'h0;
        bus.addr0  = 8'h00;
        bus.din0   = 32'h0;
        bus.csb1   = 1'b1;
        bus.addr1  = 8'h00;
    endtask

    function automatic logic [31:0] pattern(input int a);
        logic [7:0] b;
        b = 8'(a);
        return {b, ~b, b ^ 8'hA5, b + 8'd3};
    endfunction

    task automatic test_reset();
        int n;
        idle();
        rst0 = 1'b1;
        tick();
        tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL reset_busy: got %b, want 1", bus.busy); end
        total++; if (bus.dout0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_dout0: got %h, want 00000000", bus.dout0); end
        total++; if (bus.dout1 !== 32'h0) begin bad++; $display("[TB] FAIL reset_dout1: got %h, want 00000000", bus.dout1); end
        total++; if (bus.dout0_valid !== 1'b0 || bus.dout1_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_valid: got %b%b, want 00", bus.dout0_valid, bus.dout1_valid);
        end
        total++; if (bus.collision !== 1'b0) begin bad++; $display("[TB] FAIL reset_collision: got %b, want 0", bus.collision); end
        rst0 = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        total++; if (n !== 256) begin bad++; $display("[TB] FAIL busy_cycles: got %0d, want 256", n); end
    endtask

    task automatic test_clear_readback();
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 8'(i);
                bus.csb1 = 1'b0; bus.addr1 = 8'(i);
            end else begin
                idle();
            end
            tick();
            if (i >= 1) begin
                total++; if (bus.dout0_valid !== 1'b1 || bus.dout0 !== 32'h0) begin
                    bad++; $display("[TB] FAIL clear_rd0[%0d]: got v=%b d=%h, want v=1 d=00000000", i - 1, bus.dout0_valid, bus.dout0);
                end
                total++; if (bus.dout1_valid !== 1'b1 || bus.dout1 !== 32'h0) begin
                    bad++; $display("[TB] FAIL clear_rd1[%0d]: got v=%b d=%h, want v=1 d=00000000", i - 1, bus.dout1_valid, bus.dout1);
                end
            end
        end
        tick();
        total++; if (bus.dout0_valid !== 1'b0 || bus.dout1_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL clear_valid_drop: got %b%b, want 00", bus.dout0_valid, bus.dout1_valid);
        end
    endtask

    task automatic test_busy_drop();
        int n;
        int seen;
        idle();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 4'hF; bus.addr0 = 8'h10; bus.din0 = 32'hDEADBEEF;
        bus.csb1 = 1'b0; bus.addr1 = 8'h10;
        n = 0;
        seen = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            tick();
            n++;
            if (bus.dout0_valid !== 1'b0 || bus.dout1_valid !== 1'b0 || bus.collision !== 1'b0) seen++;
        end
        idle();
        total++; if (n !== 256) begin bad++; $display("[TB] FAIL busy_drop_cycles: got %0d, want 256", n); end
        total++; if (seen !== 0) begin bad++; $display("[TB] FAIL busy_strobes: got %0d, want 0", seen); end
        bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 8'h10;
        bus.csb1 = 1'b0; bus.addr1 = 8'h10;
        tick();
        idle();
        tick();
        total++; if (bus.dout0_valid !== 1'b1 || bus.dout0 !== 32'h0) begin
            bad++; $display("[TB] FAIL busy_drop_rd0: got v=%b d=%h, want v=1 d=00000000", bus.dout0_valid, bus.dout0);
        end
        total++; if (bus.dout1_valid !== 1'b1 || bus.dout1 !== 32'h0) begin
            bad++; $display("[TB] FAIL busy_drop_rd1: got v=%b d=%h, want v=1 d=00000000", bus.dout1_valid, bus.dout1);
        end
    endtask

    task automatic test_masked_write();
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 4'hF; bus.addr0 = 8'h05; bus.din0 = 32'h11223344;
        tick();
        bus.wmask0 = 4'h5; bus.din0 = 32'hAABBCCDD;
        tick();
        total++; if (bus.dout0_valid !== 1'b0) begin bad++; $display("[TB] FAIL write_no_valid: got %b, want 0", bus.dout0_valid); end
        bus.web0 = 1'b1; bus.wmask0 = 4'h0;
        tick();
        total++; if (bus.dout0_valid !== 1'b0) begin bad++; $display("[TB] FAIL latency_early: got %b, want 0", bus.dout0_valid); end
        idle();
        tick();
        total++; if (bus.dout0_valid !== 1'b1 || bus.dout0 !== 32'h11BB33DD) begin
            bad++; $display("[TB] FAIL masked_rd: got v=%b d=%h, want v=1 d=11bb33dd", bus.dout0_valid, bus.dout0);
        end
        tick();
        total++; if (bus.dout0_valid !== 1'b0 || bus.dout0 !== 32'h11BB33DD) begin
            bad++; $display("[TB] FAIL dout_hold: got v=%b d=%h, want v=0 d=11bb33dd", bus.dout0_valid, bus.dout0);
        end
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 4'h0; bus.addr0 = 8'h05; bus.din0 = 32'h0;
        tick();
        bus.web0 = 1'b1;
        tick();
        idle();
        tick();
        total++; if (bus.dout0_valid !== 1'b1 || bus.dout0 !== 32'h11BB33DD) begin
            bad++; $display("[TB] FAIL zero_mask_noop: got v=%b d=%h, want v=1 d=11bb33dd", bus.dout0_valid, bus.dout0);
        end
    endtask

    task automatic test_write_then_read();
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 4'hF; bus.addr0 = 8'h06; bus.din0 = 32'hCAFEF00D;
        tick();
        bus.web0 = 1'b1; bus.wmask0 = 4'h0;
        bus.csb1 = 1'b0; bus.addr1 = 8'h06;
        tick();
        idle();
        tick();
        total++; if (bus.dout0 !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL wr_then_rd0: got %h, want cafef00d", bus.dout0); end
        total++; if (bus.dout1 !== 32'hCAFEF00D) begin bad++; $display("[TB] FAIL wr_then_rd1: got %h, want cafef00d", bus.dout1); end
    endtask

    task automatic test_collision();
        logic [31:0] expColl;
`ifdef SRAM_BYPASS_EN
        expColl = 32'h0000FFFF;
`else
        expColl = 32'h00000000;
`endif
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 4'h3; bus.addr0 = 8'h20; bus.din0 = 32'hFFFFFFFF;
        bus.csb1 = 1'b0; bus.addr1 = 8'h20;
        tick();
        idle();
        tick();
        total++; if (bus.collision !== 1'b1 || bus.dout1_valid !== 1'b1) begin
            bad++; $display("[TB] FAIL coll_flag: got c=%b v=%b, want c=1 v=1", bus.collision, bus.dout1_valid);
        end
        total++; if (bus.dout1 !== expColl) begin bad++; $display("[TB] FAIL coll_data: got %h, want %h", bus.dout1, expColl); end
        tick();
        total++; if (bus.collision !== 1'b0) begin bad++; $display("[TB] FAIL coll_strobe: got %b, want 0", bus.collision); end
        bus.csb1 = 1'b0; bus.addr1 = 8'h20;
        tick();
        idle();
        tick();
        total++; if (bus.dout1 !== 32'h0000FFFF || bus.collision !== 1'b0) begin
            bad++; $display("[TB] FAIL coll_after: got d=%h c=%b, want d=0000ffff c=0", bus.dout1, bus.collision);
        end
        bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 4'h0; bus.addr0 = 8'h20; bus.din0 = 32'h0;
        bus.csb1 = 1'b0; bus.addr1 = 8'h20;
        tick();
        idle();
        tick();
        total++; if (bus.collision !== 1'b0 || bus.dout1 !== 32'h0000FFFF) begin
            bad++; $display("[TB] FAIL coll_zero_mask: got d=%h c=%b, want d=0000ffff c=0", bus.dout1, bus.collision);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 256; i++) begin
            bus.csb0 = 1'b0; bus.web0 = 1'b0; bus.wmask0 = 4'hF; bus.addr0 = 8'(i); bus.din0 = pattern(i);
            tick();
        end
        idle();
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 8'(i);
                bus.csb1 = 1'b0; bus.addr1 = 8'(255 - i);
            end else begin
                idle();
            end
            tick();
            if (i >= 1) begin
                total++; if (bus.dout0_valid !== 1'b1 || bus.dout0 !== pattern(i - 1)) begin
                    bad++; $display("[TB] FAIL b2b_rd0[%0d]: got v=%b d=%h, want v=1 d=%h", i - 1, bus.dout0_valid, bus.dout0, pattern(i - 1));
                end
                total++; if (bus.dout1_valid !== 1'b1 || bus.dout1 !== pattern(256 - i)) begin
                    bad++; $display("[TB] FAIL b2b_rd1[%0d]: got v=%b d=%h, want v=1 d=%h", 256 - i, bus.dout1_valid, bus.dout1, pattern(256 - i));
                end
            end
        end
        bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 8'h07;
        bus.csb1 = 1'b0; bus.addr1 = 8'h07;
        tick();
        idle();
        tick();
        total++; if (bus.dout0 !== pattern(7) || bus.dout1 !== pattern(7)) begin
            bad++; $display("[TB] FAIL same_addr_rd: got %h/%h, want %h", bus.dout0, bus.dout1, pattern(7));
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        idle();
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        repeat (100) tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_clear_busy: got %b, want 1", bus.busy); end
        rst0 = 1'b1;
        tick();
        total++; if (bus.dout0 !== 32'h0 || bus.dout1 !== 32'h0) begin
            bad++; $display("[TB] FAIL mid_reset_dout: got %h/%h, want 00000000", bus.dout0, bus.dout1);
        end
        rst0 = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        total++; if (n !== 256) begin bad++; $display("[TB] FAIL restart_cycles: got %0d, want 256", n); end
        for (int i = 0; i <= 256; i++) begin
            if (i < 256) begin
                bus.csb0 = 1'b0; bus.web0 = 1'b1; bus.addr0 = 8'(i);
                bus.csb1 = 1'b0; bus.addr1 = 8'(i);
            end else begin
                idle();
            end
            tick();
            if (i >= 1) begin
                total++; if (bus.dout0_valid !== 1'b1 || bus.dout0 !== 32'h0 || bus.dout1 !== 32'h0) begin
                    bad++; $display("[TB] FAIL reclear_rd[%0d]: got v=%b d=%h/%h, want v=1 d=00000000", i - 1, bus.dout0_valid, bus.dout0, bus.dout1);
                end
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_clear_readback();
        test_busy_drop();
        test_masked_write();
        test_write_then_read();
        test_collision();
        test_back_to_back();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
